// File: rtl/logs_pkg.sv
// Shared types and sizing helpers for the logistic-map bifurcation sweep.
package logs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESTART,
        ST_SETTLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    localparam int FRAC_DEF    = 4;
    localparam int R_W         = FRAC_DEF + 2;
    localparam int R_START_DEF = 'h30;
    localparam int R_STEP_DEF  = 'h04;
    localparam int R_END_DEF   = 'h3C;
    localparam int NCOLS       = (R_END_DEF - R_START_DEF) / R_STEP_DEF + 1;

    function automatic int ncols_of(input int r_start, input int r_end, input int r_step);
        return (r_end - r_start) / r_step + 1;
    endfunction

    // Column index width; a single-column sweep still gets one bit.
    function automatic int cw_of(input int ncols);
        return (ncols <= 1) ? 1 : $clog2(ncols);
    endfunction

endpackage

// File: rtl/logs_sample_buf.sv
// One-entry valid/ready holding register; load lands one cycle later and is held stable while stalled.
// A load into a full, undrained entry is refused and flagged as dropped; load and drain may coincide.
module logs_sample_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] sample,
    output logic         taken,
    output logic         dropped,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] held
);

    assign taken   = load & (~valid | ready);
    assign dropped = load & valid & ~ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            held  <= '0;
        end else if (taken) begin
            valid <= 1'b1;
            held  <= sample;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/logs_sweep_ctrl.sv
// Sweeps r across the bifurcation range, restarting the iterator per column and streaming orbit samples.
// Samples appear one cycle after iter_next; samples arriving while the output is stalled are counted and lost.
module logs_sweep_ctrl
    import logs_pkg::*;
#(
    parameter int FRAC    = FRAC_DEF,
    parameter int SETTLE  = 16,
    parameter int POINTS  = 8,
    parameter int R_START = R_START_DEF,
    parameter int R_STEP  = R_STEP_DEF,
    parameter int R_END   = R_END_DEF,
    parameter int CW      = cw_of(ncols_of(R_START, R_END, R_STEP))
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [FRAC+1:0] iter_r,
    output logic            iter_reset,
    input  logic            iter_next,
    input  logic [FRAC-1:0] iter_x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FRAC-1:0] out_x,
    output logic [CW-1:0]   out_col,
    output logic            busy,
    output logic            done,
    output logic [7:0]      drops
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int PW = $clog2(POINTS + 1);
    localparam logic [FRAC+1:0] R0    = (FRAC+2)'(R_START);
    localparam logic [FRAC+1:0] RSTEP = (FRAC+2)'(R_STEP);
    localparam logic [FRAC+1:0] REND  = (FRAC+2)'(R_END);

    state_t               state;
    logic [CW-1:0]        col;
    logic [SW-1:0]        settle_cnt;
    logic [PW-1:0]        pt_cnt;
    logic [FRAC+2:0]      nr;
    logic                 load;
    logic                 taken;
    logic                 dropped;
    logic [FRAC+CW-1:0]   held;

    assign load       = (state == ST_COLLECT) & iter_next;
    // One extra bit so the step past R_END cannot wrap back into range.
    assign nr         = {1'b0, iter_r} + {1'b0, RSTEP};
    assign iter_reset = reset | (state == ST_IDLE) | (state == ST_RESTART) | (state == ST_DONE);
    assign {out_x, out_col} = held;

    logs_sample_buf #(
        .W(FRAC + CW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .sample  ({iter_x, col}),
        .taken   (taken),
        .dropped (dropped),
        .valid   (out_valid),
        .ready   (out_ready),
        .held    (held)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            iter_r     <= R0;
            col        <= '0;
            settle_cnt <= '0;
            pt_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            drops      <= 8'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_RESTART;
                        iter_r <= R0;
                        col    <= '0;
                        drops  <= 8'd0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                ST_RESTART: begin
                    settle_cnt <= '0;
                    pt_cnt     <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (iter_next) begin
                        if (settle_cnt == SW'(SETTLE - 1)) begin
                            state <= ST_COLLECT;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                end
                ST_COLLECT: begin
                    if (dropped) begin
                        if (drops != 8'hFF) begin
                            drops <= drops + 8'd1;
                        end
                    end else if (taken) begin
                        if (pt_cnt == PW'(POINTS - 1)) begin
                            if (nr > {1'b0, REND}) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                iter_r <= nr[FRAC+1:0];
                                col    <= col + CW'(1);
                                state  <= ST_RESTART;
                            end
                        end else begin
                            pt_cnt <= pt_cnt + PW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logs_sweep_ctrl.sv
// Bench for logs_sweep_ctrl: emulates the logistic-map iterator and scoreboards the sample stream.
module tb_logs_sweep_ctrl;

    localparam int FRAC      = 4;
    localparam int SETTLE    = 16;
    localparam int POINTS    = 8;
    localparam int PER       = 2 * FRAC + 3;
    localparam int R_START   = 'h30;
    localparam int R_STEP    = 'h04;
    localparam int R_END     = 'h3C;
    localparam int NCOL      = (R_END - R_START) / R_STEP + 1;
    localparam int HOLD_LAST = SETTLE + 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] iter_r;
    logic       iter_reset;
    logic       iter_next;
    logic [3:0] iter_x;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_x;
    logic [1:0] out_col;
    logic       busy;
    logic       done;
    logic [7:0] drops;

    always #5 clk = ~clk;

    logs_sweep_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .iter_r     (iter_r),
        .iter_reset (iter_reset),
        .iter_next  (iter_next),
        .iter_x     (iter_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_col    (out_col),
        .busy       (busy),
        .done       (done),
        .drops      (drops)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_x[$];
    int exp_c[$];
    int cnt, pulse_no, x_it, col_seen, ir_run, handshakes, n;
    bit prev_ir, hold_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int lmap(input int r, input int x);
        return ((r * x * (16 - x)) >> 8) & 15;
    endfunction

    // Expected delivered samples per column; with hold, column 0 keeps its first
    // sample and then takes the points that follow the stalled stretch.
    task automatic build_exp(input bit hold);
        exp_x.delete();
        exp_c.delete();
        for (int c = 0; c < NCOL; c++) begin
            int r;
            int x;
            r = R_START + R_STEP * c;
            x = 8;
            for (int k = 1; k <= SETTLE + POINTS + 8; k++) begin
                x = lmap(r, x);
                if (hold && c == 0) begin
                    if (k == SETTLE + 1 || (k > HOLD_LAST && k < HOLD_LAST + POINTS)) begin
                        exp_x.push_back(x);
                        exp_c.push_back(c);
                    end
                end else if (k > SETTLE && k <= SETTLE + POINTS) begin
                    exp_x.push_back(x);
                    exp_c.push_back(c);
                end
            end
        end
    endtask

    task automatic tick();
        bit hs, pv, pr, prst;
        logic [3:0] hx;
        logic [1:0] hc;
        hs   = out_valid && out_ready && !reset;
        pv   = out_valid;
        pr   = out_ready;
        prst = reset;
        hx   = out_x;
        hc   = out_col;
        @(posedge clk);
        #1;
        if (hs) begin
            handshakes++;
            if (exp_x.size() == 0) begin
                check("extra_sample", {28'd0, hx}, 32'hFFFF_FFFF);
            end else begin
                check("sample_x", {28'd0, hx}, exp_x.pop_front());
                check("sample_col", {30'd0, hc}, exp_c.pop_front());
            end
        end
        if (pv && !pr && !prst) begin
            check("hold_valid", {31'd0, out_valid}, 1);
            check("hold_x", {28'd0, out_x}, {28'd0, hx});
            check("hold_col", {30'd0, out_col}, {30'd0, hc});
        end
        // Iterator model: restarts at x=0.5 while held in reset, then one map step per period.
        if (iter_reset) begin
            ir_run++;
            cnt = 0;
            x_it = 8;
            pulse_no = 0;
            iter_next = 1'b0;
        end else begin
            if (prev_ir) begin
                col_seen++;
                if (col_seen > 1) check("restart_len", ir_run, 1);
                check("col_r", {26'd0, iter_r}, R_START + R_STEP * (col_seen - 1));
            end
            ir_run = 0;
            cnt++;
            if (cnt == PER) begin
                cnt = 0;
                pulse_no++;
                x_it = lmap(int'(iter_r), x_it);
                iter_x = x_it[3:0];
                iter_next = 1'b1;
            end else begin
                iter_next = 1'b0;
            end
        end
        prev_ir = iter_reset;
        out_ready = !(hold_mode && col_seen == 1 && pulse_no <= HOLD_LAST);
    endtask

    task automatic begin_sweep();
        col_seen = 0;
        handshakes = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pulse(input int c, input int p);
        int k;
        k = 0;
        while (!(iter_next && col_seen == c && pulse_no == p) && k < 4000) begin
            tick();
            k++;
        end
        check("wait_pulse", pulse_no, p);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!(done && !out_valid) && k < 4000) begin
            tick();
            k++;
        end
        check("done", {31'd0, done}, 1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_valid"}, {31'd0, out_valid}, 0);
        check({pfx, "_x"}, {28'd0, out_x}, 0);
        check({pfx, "_col"}, {30'd0, out_col}, 0);
        check({pfx, "_busy"}, {31'd0, busy}, 0);
        check({pfx, "_done"}, {31'd0, done}, 0);
        check({pfx, "_drops"}, {24'd0, drops}, 0);
        check({pfx, "_iter_reset"}, {31'd0, iter_reset}, 1);
        check({pfx, "_iter_r"}, {26'd0, iter_r}, R_START);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        iter_next = 1'b0;
        iter_x = 4'd0;
        out_ready = 1'b1;
        hold_mode = 1'b0;
        prev_ir = 1'b1;
        cnt = 0; pulse_no = 0; x_it = 8; col_seen = 0; ir_run = 0; handshakes = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_vals("rst");

        // Full sweep with the consumer always ready.
        build_exp(1'b0);
        begin_sweep();
        check("restart_busy", {31'd0, busy}, 1);
        check("restart_ir", {31'd0, iter_reset}, 1);
        tick();
        check("settle_ir", {31'd0, iter_reset}, 0);
        n = 0;
        while (!out_valid && n < 1000) begin
            tick();
            n++;
        end
        check("first_latency", n, (SETTLE + 1) * PER);
        wait_done();
        check("s1_busy", {31'd0, busy}, 0);
        check("s1_drops", {24'd0, drops}, 0);
        check("s1_iter_r", {26'd0, iter_r}, R_END);
        check("s1_handshakes", handshakes, NCOL * POINTS);
        check("s1_left", exp_x.size(), 0);
        check("s1_ir", {31'd0, iter_reset}, 1);

        // Restart from DONE with column 0 stalled; start during SETTLE must be ignored.
        build_exp(1'b1);
        hold_mode = 1'b1;
        begin_sweep();
        check("done_cleared", {31'd0, done}, 0);
        check("s2_busy", {31'd0, busy}, 1);
        wait_pulse(1, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", {31'd0, busy}, 1);
        check("ign_ir", {31'd0, iter_reset}, 0);
        check("ign_iter_r", {26'd0, iter_r}, R_START);
        tick();
        check("ign_ir2", {31'd0, iter_reset}, 0);
        wait_pulse(1, HOLD_LAST);
        tick();
        check("stall_drops", {24'd0, drops}, HOLD_LAST - SETTLE - 1);
        check("stall_valid", {31'd0, out_valid}, 1);
        check("stall_x", {28'd0, out_x}, exp_x[0]);
        wait_pulse(1, HOLD_LAST + 1);
        tick();
        check("dl_valid", {31'd0, out_valid}, 1);
        check("dl_x", {28'd0, out_x}, exp_x[0]);
        check("dl_col", {30'd0, out_col}, 0);
        check("dl_drops", {24'd0, drops}, HOLD_LAST - SETTLE - 1);
        wait_done();
        check("s2_handshakes", handshakes, NCOL * POINTS);
        check("s2_drops", {24'd0, drops}, HOLD_LAST - SETTLE - 1);
        check("s2_left", exp_x.size(), 0);
        hold_mode = 1'b0;

        // Reset in the middle of column 2 collection, with a sample pending.
        build_exp(1'b0);
        begin_sweep();
        wait_pulse(3, SETTLE + 3);
        tick();
        check("pend_valid", {31'd0, out_valid}, 1);
        reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b0;
        tick();

        // Fresh sweep after the reset starts over from column 0.
        build_exp(1'b0);
        begin_sweep();
        check("s4_iter_r", {26'd0, iter_r}, R_START);
        wait_done();
        check("s4_handshakes", handshakes, NCOL * POINTS);
        check("s4_drops", {24'd0, drops}, 0);
        check("s4_left", exp_x.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
